// File: rtl/uart_rx_parity_check.sv
// UART receive deserialiser: oversampled start/data/parity/stop frames, LSB first, parity + framing check.
// Latency: data_valid pulses one HCLK after the mid-stop sample; rx_in passes a 2-FF synchroniser first.
// No backpressure: data_valid is a 1-cycle strobe that the consumer must take. Option: UART_RX_PARITY_FAULT_INJECTION_EN.
module uart_rx_parity_check #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  baud_tick,
  input  logic                  rx_in,
  input  logic                  parity_en,
  input  logic                  is_even_parity,
`ifdef UART_RX_PARITY_FAULT_INJECTION_EN
  input  logic                  parity_fault_injection,
`endif
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state, state_d;
  logic                   rx_meta, rxs, rxp;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_WIDTH-1:0]  shreg;
  logic                   par_en_q, even_q, p_rx;
  logic                   fall, mid_hit, end_hit, shift_en, stop_en;
  logic                   exp_par, perr;

  // Two-flop synchroniser plus a previous-value flop for falling-edge detection
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxp     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
      rxp     <= rxs;
    end
  end

  assign fall    = rxp & ~rxs;
  assign mid_hit = baud_tick && (cnt == CNT_MID);
  assign end_hit = baud_tick && (cnt == CNT_END);

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next-state logic; shift_en/stop_en mark the mid-bit sample points
  always_comb begin
    state_d  = state;
    shift_en = 1'b0;
    stop_en  = 1'b0;
    case (state)
      S_IDLE:   if (fall) state_d = S_START;
      S_START:  if (mid_hit) state_d = rxs ? S_IDLE : S_DATA;
      S_DATA:   if (end_hit) begin
                  shift_en = 1'b1;
                  if (bit_idx == BIT_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
                end
      S_PARITY: if (end_hit) state_d = S_STOP;
      S_STOP:   if (end_hit) begin
                  stop_en = 1'b1;
                  state_d = S_IDLE;
                end
      default:  state_d = S_IDLE;
    endcase
  end

  // Tick counter restarts on every state entry and after each data bit
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                            cnt <= '0;
    else if (state_d != state || shift_en)   cnt <= '0;
    else if (baud_tick && state != S_IDLE)   cnt <= cnt + CW'(1);
  end

  // Data bit index and LSB-first shift register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == S_START) begin
      bit_idx <= '0;
    end else if (shift_en) begin
      bit_idx <= bit_idx + BW'(1);
      shreg   <= {rxs, shreg[DATA_WIDTH-1:1]};
    end
  end

  // Frame configuration is frozen at start detection; parity bit captured mid-bit
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      par_en_q <= 1'b0;
      even_q   <= 1'b0;
      p_rx     <= 1'b0;
    end else begin
      if (state == S_IDLE && fall) begin
        par_en_q <= parity_en;
        even_q   <= is_even_parity;
      end
      if (state == S_PARITY && end_hit) p_rx <= rxs;
    end
  end

`ifdef UART_RX_PARITY_FAULT_INJECTION_EN
  logic fault_q;

  // Fault-injection request is frozen with the rest of the frame configuration
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                     fault_q <= 1'b0;
    else if (state == S_IDLE && fall) fault_q <= parity_fault_injection;
  end

  assign exp_par = (even_q ? ^shreg : ~^shreg) ^ fault_q;
`else
  assign exp_par = even_q ? ^shreg : ~^shreg;
`endif

  assign perr = par_en_q & (p_rx != exp_par);

  // Result registers: all update together one cycle after the stop sample
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid <= stop_en;
      if (stop_en) begin
        data_out      <= shreg;
        framing_error <= ~rxs;
        parity_error  <= perr;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_parity_check.sv
module tb_uart_rx_parity_check;

  localparam int OS  = 16;
  localparam int DIV = 4;

  logic       HCLK, HRESETn, baud_tick, rx_in, parity_en, is_even_parity;
`ifdef UART_RX_PARITY_FAULT_INJECTION_EN
  logic       parity_fault_injection;
`endif
  logic [7:0] data_out;
  logic       data_valid, parity_error, framing_error, busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   dv_count = 0;
  int   exp_dv = 0;

  uart_rx_parity_check #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
    .HCLK                   (HCLK),
    .HRESETn                (HRESETn),
    .baud_tick              (baud_tick),
    .rx_in                  (rx_in),
    .parity_en              (parity_en),
    .is_even_parity         (is_even_parity),
`ifdef UART_RX_PARITY_FAULT_INJECTION_EN
    .parity_fault_injection (parity_fault_injection),
`endif
    .data_out               (data_out),
    .data_valid             (data_valid),
    .parity_error           (parity_error),
    .framing_error          (framing_error),
    .busy                   (busy)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // baud_tick: one HCLK high every DIV cycles, changed on the falling edge
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (DIV - 1) @(negedge HCLK);
      baud_tick = 1'b1;
      @(negedge HCLK);
      baud_tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every data_valid cycle pops one expected frame
  always @(negedge HCLK) begin
    if (HRESETn === 1'b1 && data_valid === 1'b1) begin
      dv_count++;
      chk("sb_nonempty", sb.size(), sb.size() == 0 ? 32'd1 : sb.size());
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("data_out", data_out, e.data);
        chk("parity_error", parity_error, e.perr);
        chk("framing_error", framing_error, e.ferr);
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic en, input logic even,
                          input logic p, input logic stop, input logic fault);
    exp_t e;
    logic expect_p;
    expect_p = (even ? ^d : ~^d) ^ fault;
    e.data = d;
    e.perr = en & (p != expect_p);
    e.ferr = ~stop;
    sb.push_back(e);
    exp_dv++;
  endtask

  // Drive one level for n baud ticks, then step to the next falling HCLK edge
  task automatic hold_bit(input logic v, input int n);
    rx_in = v;
    repeat (n) begin
      @(posedge HCLK);
      while (baud_tick !== 1'b1) @(posedge HCLK);
    end
    @(negedge HCLK);
  endtask

  task automatic send_tail(input logic [7:0] d, input logic has_par, input logic p, input logic stop);
    for (int i = 0; i < 8; i++) hold_bit(d[i], OS);
    if (has_par) hold_bit(p, OS);
    hold_bit(stop, OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic p, input logic stop);
    hold_bit(1'b0, OS);
    send_tail(d, has_par, p, stop);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_dv_count"}, dv_count, exp_dv);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    HRESETn = 1'b1;
    rx_in = 1'b1;
    parity_en = 1'b1;
    is_even_parity = 1'b1;
`ifdef UART_RX_PARITY_FAULT_INJECTION_EN
    parity_fault_injection = 1'b0;
`endif
    #1 HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_parity_error", parity_error, 0);
    chk("rst_framing_error", framing_error, 0);
    chk("rst_busy", busy, 0);
    HRESETn = 1'b1;
    hold_bit(1'b1, OS);
    chk("idle_busy", busy, 0);

    // Even parity 0xA5, good parity; config changed mid-frame must be ignored
    push_exp(8'hA5, 1, 1, 0, 1, 0);
    hold_bit(1'b0, OS);
    chk("start_busy", busy, 1);
    is_even_parity = 1'b0;
    parity_en = 1'b0;
    send_tail(8'hA5, 1, 0, 1);
    hold_bit(1'b1, OS);
    chk_drained("t1");

    // Odd parity 0x01: wrong parity bit, then correct parity bit
    parity_en = 1'b1;
    is_even_parity = 1'b0;
    push_exp(8'h01, 1, 0, 1, 1, 0);
    send_frame(8'h01, 1, 1, 1);
    hold_bit(1'b1, OS);
    chk("t2_perr_held", parity_error, 1);
    push_exp(8'h01, 1, 0, 0, 1, 0);
    send_frame(8'h01, 1, 0, 1);
    hold_bit(1'b1, OS);
    chk_drained("t2");

    // No parity, 0x3C with stop=0, line then held low
    parity_en = 1'b0;
    push_exp(8'h3C, 0, 0, 0, 0, 0);
    send_frame(8'h3C, 0, 0, 0);
    hold_bit(1'b0, 3 * OS);
    chk("t3_low_busy", busy, 0);
    chk_drained("t3_low");
    hold_bit(1'b1, 2 * OS);
    chk("t3_high_busy", busy, 0);
    chk("t3_ferr_held", framing_error, 1);
    chk("t3_data_held", data_out, 8'h3C);
    chk_drained("t3");

    // False start: 4-tick low pulse, receiver gives up at the mid-start sample
    hold_bit(1'b0, 4);
    chk("t4_busy_pulse", busy, 1);
    hold_bit(1'b1, 2);
    chk("t4_busy_before_mid", busy, 1);
    hold_bit(1'b1, 4);
    chk("t4_busy_after_mid", busy, 0);
    hold_bit(1'b1, OS);
    chk_drained("t4");

    // Back-to-back frames with one stop bit
    parity_en = 1'b1;
    is_even_parity = 1'b1;
    push_exp(8'h55, 1, 1, 0, 1, 0);
    push_exp(8'hAA, 1, 1, 0, 1, 0);
    send_frame(8'h55, 1, 0, 1);
    send_frame(8'hAA, 1, 0, 1);
    hold_bit(1'b1, OS);
    chk_drained("t5");

    // Frame with both errors, then reset in the middle of the next frame's data
    is_even_parity = 1'b0;
    push_exp(8'h01, 1, 0, 1, 0, 0);
    send_frame(8'h01, 1, 1, 0);
    hold_bit(1'b1, OS);
    chk("t6_perr_set", parity_error, 1);
    chk("t6_ferr_set", framing_error, 1);
    hold_bit(1'b0, OS);
    hold_bit(1'b1, OS);
    hold_bit(1'b0, OS);
    HRESETn = 1'b0;
    rx_in = 1'b1;
    repeat (2) @(negedge HCLK);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_parity_error", parity_error, 0);
    chk("mid_rst_framing_error", framing_error, 0);
    chk("mid_rst_busy", busy, 0);
    HRESETn = 1'b1;
    hold_bit(1'b1, 3 * OS);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_data_out", data_out, 0);
    chk_drained("t6");

`ifdef UART_RX_PARITY_FAULT_INJECTION_EN
    // Fault injection flips the expected parity of a correct frame
    is_even_parity = 1'b1;
    parity_fault_injection = 1'b1;
    push_exp(8'hA5, 1, 1, 0, 1, 1);
    send_frame(8'hA5, 1, 0, 1);
    parity_fault_injection = 1'b0;
    hold_bit(1'b1, OS);
    chk("t7_perr_injected", parity_error, 1);
    chk_drained("t7");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
